// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the PRBS generator / checker pair.
//   FB_TAPS    : number of top bits XORed into the feedback bit
//   LFSR_MAX_W : widest word lfsr_nxt() can handle
//   lfsr_state_t : checker state (SEARCH, LOCKED)
//   lfsr_nxt(x, len) : next LFSR word for a len-bit register held in the
//                      low bits of x (left shift, feedback = XOR of the top
//                      FB_TAPS bits); bits at and above len are returned 0.
// -----------------------------------------------------------------------------
package lfsr_pkg;

    localparam int FB_TAPS    = 8;
    localparam int LFSR_MAX_W = 64;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } lfsr_state_t;

    function automatic logic [LFSR_MAX_W-1:0] lfsr_nxt(input logic [LFSR_MAX_W-1:0] x,
                                                         input int                    len);
        logic                  fb;
        logic [LFSR_MAX_W-1:0] y;
        fb = 1'b0;
        for (int i = 0; i < LFSR_MAX_W; i++) begin
            if (i >= len - FB_TAPS && i < len) begin
                fb = fb ^ x[i];
            end
        end
        y = {x[LFSR_MAX_W-2:0], fb};
        // Drop the bit shifted out of the top of the len-bit register.
        for (int i = 0; i < LFSR_MAX_W; i++) begin
            if (i >= len) begin
                y[i] = 1'b0;
            end
        end
        return y;
    endfunction

endpackage

// File: rtl/lfsr_popcount.sv
// -----------------------------------------------------------------------------
// lfsr_popcount
// Combinational population count of a NUM_LEN-bit word.
//   x   : input word
//   cnt : number of set bits in x (OUT_W bits, must hold NUM_LEN)
// -----------------------------------------------------------------------------
module lfsr_popcount #(
    parameter int NUM_LEN = 10,
    parameter int OUT_W   = $clog2(NUM_LEN + 1)
) (
    input  logic [NUM_LEN-1:0] x,
    output logic [OUT_W-1:0]   cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < NUM_LEN; i++) begin
            cnt = cnt + OUT_W'(x[i]);
        end
    end

endmodule

// File: rtl/lfsr_checker.sv
// -----------------------------------------------------------------------------
// lfsr_checker
// Receive-side checker for the maximal-length LFSR generator. It seeds its
// predictor from the incoming stream, declares lock after LOCK_CNT correct
// predictions, then free-runs its predictor (flywheel) and counts mismatching
// words. LOSS_CNT consecutive mismatches while locked force a re-search.
//
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   en         : din valid this cycle
//   din        : received LFSR word (NUM_LEN bits)
//   clr_err    : synchronous clear of err_cnt and err_sticky
//   locked     : checker is in LOCKED
//   err_pulse  : one-cycle pulse for a mismatching word while locked
//   err_cnt    : saturating error count (CNT_W bits)
//   err_sticky : set on any error while locked, cleared by clr_err
//
// Build option:
//   LFSR_CHK_BITERR_EN : when defined, each mismatching word adds the number
//                        of differing bits to err_cnt instead of 1.
// -----------------------------------------------------------------------------
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int NUM_LEN  = 10,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_LEN-1:0] din,
    input  logic               clr_err,
    output logic               locked,
    output logic               err_pulse,
    output logic [CNT_W-1:0]   err_cnt,
    output logic               err_sticky
);

    // The run counter serves both the lock search and the loss count.
    localparam int RUN_MAX = (LOCK_CNT + 1 > LOSS_CNT) ? LOCK_CNT + 1 : LOSS_CNT;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);
    localparam int INC_W   = $clog2(NUM_LEN + 1);
    localparam int SUM_W   = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;

    // Add with one guard bit, clamp to all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                                 input logic [INC_W-1:0] inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(base) + SUM_W'(inc);
        if (sum > SUM_W'({CNT_W{1'b1}})) begin
            return {CNT_W{1'b1}};
        end
        return sum[CNT_W-1:0];
    endfunction

    lfsr_state_t        state_p1;
    logic [NUM_LEN-1:0] pred_p1;
    logic [RUN_W-1:0]   run_p1;

    logic [NUM_LEN-1:0] din_nxt;
    logic [NUM_LEN-1:0] pred_nxt;
    logic [INC_W-1:0]   err_inc;
    logic [CNT_W-1:0]   err_cnt_new;
    logic               din_zero;
    logic               din_match;

    assign din_nxt   = NUM_LEN'(lfsr_nxt(LFSR_MAX_W'(din), NUM_LEN));
    assign pred_nxt  = NUM_LEN'(lfsr_nxt(LFSR_MAX_W'(pred_p1), NUM_LEN));
    assign din_zero  = (din == '0);
    assign din_match = (din == pred_p1);

`ifdef LFSR_CHK_BITERR_EN
    logic [INC_W-1:0] bit_errs;

    lfsr_popcount #(
        .NUM_LEN (NUM_LEN),
        .OUT_W   (INC_W)
    ) u_popcount (
        .x   (din ^ pred_p1),
        .cnt (bit_errs)
    );

    assign err_inc = bit_errs;
`else
    assign err_inc = INC_W'(1);
`endif

    // A clear coincident with a new error discards the old count first.
    assign err_cnt_new = sat_add(clr_err ? {CNT_W{1'b0}} : err_cnt, err_inc);

    // Stage p1: predictor, run counter, lock state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1   <= SEARCH;
            pred_p1    <= '0;
            run_p1     <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (clr_err) begin
                err_cnt    <= '0;
                err_sticky <= 1'b0;
            end
            if (en) begin
                case (state_p1)
                    SEARCH: begin
                        if (din_zero) begin
                            // The all-zero word is a lock-up state, never a seed.
                            run_p1 <= '0;
                        end else if (run_p1 != '0 && din_match) begin
                            pred_p1 <= din_nxt;
                            if (run_p1 == RUN_W'(LOCK_CNT)) begin
                                state_p1 <= LOCKED;
                                locked   <= 1'b1;
                                run_p1   <= '0;
                            end else begin
                                run_p1 <= run_p1 + RUN_W'(1);
                            end
                        end else begin
                            pred_p1 <= din_nxt;
                            run_p1  <= RUN_W'(1);
                        end
                    end
                    LOCKED: begin
                        // Flywheel: the predictor never follows din once locked,
                        // so one corrupted word costs exactly one error.
                        pred_p1 <= pred_nxt;
                        if (din_match) begin
                            run_p1 <= '0;
                        end else begin
                            err_pulse  <= 1'b1;
                            err_cnt    <= err_cnt_new;
                            err_sticky <= 1'b1;
                            if (run_p1 == RUN_W'(LOSS_CNT - 1)) begin
                                state_p1 <= SEARCH;
                                locked   <= 1'b0;
                                run_p1   <= '0;
                            end else begin
                                run_p1 <= run_p1 + RUN_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_p1 <= SEARCH;
                        locked   <= 1'b0;
                        run_p1   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
